reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register-file address width.
REQ-002 SHALL have parameter DATA_W, default 20, register-file data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_0/req_1  input  1  access request from requester 0/1.
REQ-006 SHALL have ports we_0/we_1  input  1  1 = write, 0 = read, valid while req_x high.
REQ-007 SHALL have ports addr_0/addr_1  input  ADDR_W  target address, valid while req_x high.
REQ-008 SHALL have ports wdata_0/wdata_1  input  DATA_W  write data, valid while req_x high.
REQ-009 SHALL have ports gnt_0/gnt_1  output  1  one-cycle grant pulse.
REQ-010 SHALL have ports rvalid_0/rvalid_1  output  1  one-cycle read-data-valid pulse.
REQ-011 SHALL have port rdata  output  DATA_W  read data, shared, qualified by rvalid_x.
REQ-012 SHALL have ports WrEn, RdEn  output  1 each  register-file write/read enables.
REQ-013 SHALL have ports Address  output  ADDR_W, WrData  output  DATA_W  register-file command.
REQ-014 SHALL have port RdData  input  DATA_W  register-file read data, valid one cycle after RdEn.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CMD, RDWAIT.
REQ-017 IDLE: if any req_x high, SHALL select a winner, register its we/addr/wdata and go to CMD; else stay IDLE.
REQ-018 CMD (one cycle): SHALL drive Address/WrData from the latched command, WrEn=we or RdEn=~we (never both), and gnt of winner =1.
REQ-019 CMD -> IDLE for writes; CMD -> RDWAIT for reads.
REQ-020 RDWAIT (one cycle): SHALL capture RdData into rdata and pulse rvalid of winner; -> IDLE.
REQ-021 Requester SHALL hold req/payload until gnt seen and deassert at following edge; arbiter samples req only in IDLE, so no double grant.
REQ-022 Throughput: write = 2 cycles req-to-req, read = 3 cycles; read latency req-to-rvalid = 3 cycles from IDLE.
REQ-023 Round-robin: 1-bit pointer points at the preferred port; on simultaneous req the pointer port wins; pointer SHALL move to the other port after each grant.
REQ-024 Single requester SHALL win regardless of pointer.
REQ-025 WrEn, RdEn, gnt_x, rvalid_x SHALL be low in all states except as stated; rdata holds last captured value.
REQ-026 All 2^ADDR_W addresses legal; no address wrap/translation.

Reset
REQ-027 On rst: state=IDLE, pointer=port 0, WrEn=RdEn=0, gnt_x=rvalid_x=0, busy=0, Address=0, WrData=0, rdata=0.
REQ-028 Reset asserted in CMD or RDWAIT SHALL abort immediately; no rvalid SHALL be issued for the aborted read, and requester re-requests.

Configuration
REQ-029 Macro REG_ARB_FIXED_PRIO_EN defined: port 0 SHALL always win simultaneous requests, pointer removed.
REQ-030 Macro undefined: round-robin per REQ-023.

Structure
REQ-031 Package reg_arb_pkg SHALL hold the state enum type, ADDR_W/DATA_W default constants and the latched-command struct (we, addr, wdata, port id).
REQ-032 Winner selection SHALL be a sub-module rr_arb2 (2-way, pointer inside, fixed-priority variant under REG_ARB_FIXED_PRIO_EN).

Verification
REQ-033 req_0 write addr=3 wdata=20'hABCDE -> next cycle CMD: WrEn=1, Address=3, WrData=ABCDE, gnt_0=1; busy 1 cycle.
REQ-034 req_1 read addr=3 after REQ-033 -> RdEn=1 in CMD, gnt_1=1; next cycle rvalid_1=1, rdata=ABCDE.
REQ-035 req_0 and req_1 both held continuously, both writes -> gnt order 0,1,0,1 (round-robin); 0,0,0 with REG_ARB_FIXED_PRIO_EN.
REQ-036 rst asserted during RDWAIT of port-0 read -> all outputs 0 same cycle, no rvalid_0, pointer=0.
REQ-037 Back-to-back: write addr=15 data=20'hFFFFF then read addr=15 from same port -> rvalid with rdata=FFFFF, total 5 cycles.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and defaults for the two-port register-file arbiter.
package reg_arb_pkg;

  localparam int unsigned AddrWDef = 4;
  localparam int unsigned DataWDef = 20;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StRdWait
  } state_e;

  // Command latched from the winning requester; sized by the default widths above.
  typedef struct packed {
    logic                we;
    logic [AddrWDef-1:0] addr;
    logic [DataWDef-1:0] wdata;
    logic                port;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way winner select for reg_arbiter.
// Default: round-robin with a 1-bit preference pointer.
// REG_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie, no pointer state.
module rr_arb2 (
`ifndef REG_ARB_FIXED_PRIO_EN
  input  logic clk,
  input  logic rst,
  input  logic advance,
`endif
  input  logic req_0,
  input  logic req_1,
  output logic any_req,
  output logic winner
);

`ifndef REG_ARB_FIXED_PRIO_EN
  logic ptr_q;

  // Tie goes to the pointer port; a lone requester wins regardless of the pointer.
  always_comb begin
    any_req = req_0 | req_1;
    winner  = (req_0 & req_1) ? ptr_q : req_1;
  end

  // After every grant, prefer the port that did not win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= ~winner;
    end
  end
`else
  // Port 0 has absolute priority.
  always_comb begin
    any_req = req_0 | req_1;
    winner  = req_1 & ~req_0;
  end
`endif

endmodule

// File: rtl/reg_arbiter.sv
// reg_arbiter: two requesters sharing one register file through an IDLE/CMD/RDWAIT FSM.
// Writes take 2 cycles req-to-req, reads 3. Build option REG_ARB_FIXED_PRIO_EN selects
// fixed priority (port 0) instead of round-robin in rr_arb2.
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData,
  output logic              busy
);

  state_e            state_q;
  cmd_t              cmd_q;
  cmd_t              cmd_sel;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;
  logic              winner;

`ifndef REG_ARB_FIXED_PRIO_EN
  logic advance;

  // The pointer moves only when a request is actually accepted.
  always_comb begin
    advance = (state_q == StIdle) & any_req;
  end
`endif

  rr_arb2 u_rr_arb2 (
`ifndef REG_ARB_FIXED_PRIO_EN
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
`endif
    .req_0   (req_0),
    .req_1   (req_1),
    .any_req (any_req),
    .winner  (winner)
  );

  // Payload of whichever port the arbiter picked this cycle.
  always_comb begin
    cmd_sel       = '0;
    cmd_sel.we    = winner ? we_1 : we_0;
    cmd_sel.addr  = winner ? addr_1 : addr_0;
    cmd_sel.wdata = winner ? wdata_1 : wdata_0;
    cmd_sel.port  = winner;
  end

  // Register-file command comes straight from the latched command; RdData is only valid
  // during RDWAIT, so it is passed through there and the held copy is shown otherwise.
  always_comb begin
    Address = cmd_q.addr;
    WrData  = cmd_q.wdata;
    busy    = (state_q != StIdle);
    rdata   = (state_q == StRdWait) ? RdData : rdata_q;
  end

  // Control FSM with registered one-cycle strobes; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      rdata_q  <= '0;
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      gnt_0    <= 1'b0;
      gnt_1    <= 1'b0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
    end else begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      gnt_0    <= 1'b0;
      gnt_1    <= 1'b0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            cmd_q   <= cmd_sel;
            WrEn    <= cmd_sel.we;
            RdEn    <= ~cmd_sel.we;
            gnt_0   <= ~winner;
            gnt_1   <= winner;
            state_q <= StCmd;
          end
        end
        StCmd: begin
          if (cmd_q.we) begin
            state_q <= StIdle;
          end else begin
            rvalid_0 <= ~cmd_q.port;
            rvalid_1 <= cmd_q.port;
            state_q  <= StRdWait;
          end
        end
        StRdWait: begin
          rdata_q <= RdData;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: directed scenarios plus randomized traffic checked each cycle against a
// transaction-level schedule model of the arbiter.
module tb_reg_arbiter;

  localparam int AW = 4;
  localparam int DW = 20;

  logic          clk;
  logic          rst;
  logic          req_0, req_1, we_0, we_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [DW-1:0] rdata;
  logic          WrEn, RdEn;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData;
  logic          busy;

  int checks = 0;
  int errors = 0;

  reg_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_0    (req_0),
    .req_1    (req_1),
    .we_0     (we_0),
    .we_1     (we_1),
    .addr_0   (addr_0),
    .addr_1   (addr_1),
    .wdata_0  (wdata_0),
    .wdata_1  (wdata_1),
    .gnt_0    (gnt_0),
    .gnt_1    (gnt_1),
    .rvalid_0 (rvalid_0),
    .rvalid_1 (rvalid_1),
    .rdata    (rdata),
    .WrEn     (WrEn),
    .RdEn     (RdEn),
    .Address  (Address),
    .WrData   (WrData),
    .RdData   (RdData),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous write, registered read (data one cycle after RdEn).
  logic [DW-1:0] rf [16];
  bit            rf_init;
  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      rf_init <= 1'b1;
    end else begin
      if (WrEn) rf[Address] <= WrData;
      if (RdEn) RdData <= rf[Address];
    end
  end

  typedef struct packed {
    logic          busy;
    logic          g0;
    logic          g1;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          rv0;
    logic          rv1;
    logic [DW-1:0] rd;
  } vec_t;

  function automatic logic [63:0] dut_vec();
    return 64'({busy, gnt_0, gnt_1, WrEn, RdEn, Address, WrData, rvalid_0, rvalid_1, rdata});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Schedule model: an accepted request books its CMD cycle (and RDWAIT for reads) ahead.
  initial begin : model
    vec_t          q[$];
    vec_t          exp;
    vec_t          v;
    logic          ptr;
    logic          idle;
    logic          w;
    logic          pwe;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_wd;
    logic [DW-1:0] hold_rd;
    logic [DW-1:0] ref_mem [16];
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ptr = 1'b0;
    hold_addr = '0;
    hold_wd = '0;
    hold_rd = '0;
    forever begin
      @(negedge clk);
      idle = 1'b0;
      if (rst) begin
        q.delete();
        ptr = 1'b0;
        hold_addr = '0;
        hold_wd = '0;
        hold_rd = '0;
        exp = '0;
      end else if (q.size() == 0) begin
        idle = 1'b1;
        exp = '0;
        exp.addr = hold_addr;
        exp.wd = hold_wd;
        exp.rd = hold_rd;
      end else begin
        exp = q.pop_front();
        if (exp.rv0 | exp.rv1) hold_rd = exp.rd;
      end
      chk("cycle", dut_vec(), 64'(exp));
      if (idle && (req_0 || req_1)) begin
`ifdef REG_ARB_FIXED_PRIO_EN
        w = req_0 ? 1'b0 : 1'b1;
`else
        w = (req_0 && req_1) ? ptr : req_1;
        ptr = ~w;
`endif
        pwe = w ? we_1 : we_0;
        pa = w ? addr_1 : addr_0;
        pd = w ? wdata_1 : wdata_0;
        hold_addr = pa;
        hold_wd = pd;
        v = '0;
        v.busy = 1'b1;
        v.g0 = ~w;
        v.g1 = w;
        v.we = pwe;
        v.re = ~pwe;
        v.addr = pa;
        v.wd = pd;
        v.rd = hold_rd;
        q.push_back(v);
        if (pwe) begin
          ref_mem[pa] = pd;
        end else begin
          v = '0;
          v.busy = 1'b1;
          v.addr = pa;
          v.wd = pd;
          v.rv0 = ~w;
          v.rv1 = w;
          v.rd = ref_mem[pa];
          q.push_back(v);
        end
      end
    end
  end

  // One cycle of random requester behaviour: drop after gnt, maybe raise a new request.
  task automatic cyc(input int unsigned pct0, input int unsigned pct1, input int unsigned wr_pct);
    logic g0s, g1s;
    @(negedge clk);
    g0s = gnt_0;
    g1s = gnt_1;
    @(posedge clk);
    #1;
    if (req_0 && g0s) req_0 = 1'b0;
    if (req_1 && g1s) req_1 = 1'b0;
    if (!req_0 && ($urandom_range(99) < pct0)) begin
      req_0 = 1'b1;
      we_0 = ($urandom_range(99) < wr_pct);
      addr_0 = AW'($urandom);
      wdata_0 = DW'($urandom);
    end
    if (!req_1 && ($urandom_range(99) < pct1)) begin
      req_1 = 1'b1;
      we_1 = ($urandom_range(99) < wr_pct);
      addr_1 = AW'($urandom);
      wdata_1 = DW'($urandom);
    end
  endtask

  initial begin : stim
    int order [8];
    int exp_order [4];
    int ng;
    int n;
    logic g;
    logic done;
    rst = 1'b1;
    req_0 = 1'b0;
    req_1 = 1'b0;
    we_0 = 1'b0;
    we_1 = 1'b0;
    addr_0 = '0;
    addr_1 = '0;
    wdata_0 = '0;
    wdata_1 = '0;

    @(negedge clk);
    chk("reset_outputs", dut_vec(), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Port 0 write, addr 3.
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd3; wdata_0 = 20'hABCDE;
    @(negedge clk);
    chk("idle_before_grant_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("wr_cmd_wren", 64'(WrEn), 64'd1);
    chk("wr_cmd_rden", 64'(RdEn), 64'd0);
    chk("wr_cmd_address", 64'(Address), 64'd3);
    chk("wr_cmd_wrdata", 64'(WrData), 64'hABCDE);
    chk("wr_cmd_gnt0", 64'({gnt_0, gnt_1}), 64'b10);
    @(posedge clk);
    #1;
    req_0 = 1'b0;
    @(negedge clk);
    chk("wr_busy_one_cycle", 64'({busy, WrEn}), 64'd0);

    // Port 1 read, addr 3.
    @(posedge clk);
    #1;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'd3;
    @(negedge clk);
    @(negedge clk);
    chk("rd_cmd_rden_gnt1", 64'({RdEn, WrEn, gnt_0, gnt_1}), 64'b1001);
    @(posedge clk);
    #1;
    req_1 = 1'b0;
    @(negedge clk);
    chk("rd_rvalid1", 64'({rvalid_0, rvalid_1}), 64'b01);
    chk("rd_rdata", 64'(rdata), 64'hABCDE);
    @(negedge clk);
    chk("rd_rvalid_pulse_end", 64'({rvalid_0, rvalid_1, busy}), 64'd0);
    chk("rd_rdata_held", 64'(rdata), 64'hABCDE);

    // Both ports hold write requests continuously.
    @(posedge clk);
    #1;
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd5; wdata_0 = 20'h11111;
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 4'd6; wdata_1 = 20'h22222;
    ng = 0;
    for (int i = 0; i < 20 && ng < 4; i++) begin
      @(negedge clk);
      if (gnt_0) begin order[ng] = 0; ng++; end
      if (gnt_1) begin order[ng] = 1; ng++; end
    end
    @(posedge clk);
    #1;
    req_0 = 1'b0;
    req_1 = 1'b0;
    chk("contend_grants_seen", 64'(ng >= 4), 64'd1);
    for (int k = 0; k < 4; k++) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      exp_order[k] = 0;
`else
      exp_order[k] = k % 2;
`endif
      chk($sformatf("contend_order_%0d", k), 64'(order[k]), 64'(exp_order[k]));
    end

    // Port 0 read aborted by reset during RDWAIT.
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd3;
    @(negedge clk);
    @(negedge clk);
    chk("abort_rd_gnt0", 64'({gnt_0, RdEn}), 64'b11);
    @(posedge clk);
    #1;
    req_0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs_zero", dut_vec(), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd7; wdata_0 = 20'h77777;
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 4'd8; wdata_1 = 20'h88888;
    @(negedge clk);
    @(negedge clk);
    chk("ptr_after_reset", 64'({gnt_0, gnt_1}), 64'b10);
    @(posedge clk);
    #1;
    req_0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("lone_port1_grant", 64'({gnt_0, gnt_1}), 64'b01);
    @(posedge clk);
    #1;
    req_1 = 1'b0;

    // Back-to-back write then read of addr 15 from port 0.
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd15; wdata_0 = 20'hFFFFF;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      n++;
      g = gnt_0;
      if (rvalid_0) begin
        chk("b2b_rdata", 64'(rdata), 64'hFFFFF);
        chk("b2b_cycles", 64'(n), 64'd5);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (g) begin
        if (we_0) we_0 = 1'b0;
        else req_0 = 1'b0;
      end
    end
    chk("b2b_completed", 64'(done), 64'd1);
    req_0 = 1'b0;

    // Random traffic, then drain.
    for (int i = 0; i < 3000; i++) cyc(45, 45, 50);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
